gbuff_row_feeder: RTL and testbench

//  Read-side sequencer between global_buffer and the systolic array input edge.
//  On a start command it streams LEN consecutive words from the global buffer, starting at BASE.

---
 rtl/gbuff_row_feeder_pkg.sv | 28 ++
 rtl/gbuff_row_feeder_skew_line.sv | 41 ++++
 rtl/gbuff_row_feeder.sv | 133 +++++++++++++
 tb/tb_gbuff_row_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gbuff_row_feeder_pkg.sv
// Shared sizes and state encoding for the global-buffer row feeder.
// The drain length is also derived here so the FSM and its counter width stay in sync.
package gbuff_row_feeder_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int GBUFF_INDX_SIZE = 16;
    localparam int DATA_W          = 8;
    localparam int ROWS            = WORD_SIZE / DATA_W;
    localparam int IDX_W           = GBUFF_INDX_SIZE;
    localparam int LEN_W           = 9;

    // Drain covers read latency, ROWS-1 skew stages, the output register and one settle cycle.
    localparam int DRAIN_CYCLES = ROWS + 2;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/gbuff_row_feeder_skew_line.sv
// Fixed-depth delay line carrying one lane's operand together with its valid bit.
// DEPTH=0 is a pure wire so lane 0 only sees the shared output register.
module skew_line
    import gbuff_row_feeder_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_data = in_data;
            assign out_vld  = in_vld;
        end else begin : g_pipe
            logic [DATA_W:0] pipe_reg [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe_reg[i] <= '0;
                    end
                end else begin
                    pipe_reg[0] <= {in_vld, in_data};
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe_reg[i] <= pipe_reg[i-1];
                    end
                end
            end

            assign out_vld  = pipe_reg[DEPTH-1][DATA_W];
            assign out_data = pipe_reg[DEPTH-1][DATA_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/gbuff_row_feeder.sv
// Streams LEN words from the global buffer starting at BASE and skews byte lane r
// by r cycles, producing the diagonal wavefront for the systolic array's left edge.
module gbuff_row_feeder
    import gbuff_row_feeder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IDX_W-1:0]       base,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    output logic                   gb_wr_en,
    output logic [IDX_W-1:0]       gb_index,
    input  logic [WORD_SIZE-1:0]   gb_data,
    output logic [ROWS*DATA_W-1:0] lane_data,
    output logic [ROWS-1:0]        lane_vld
);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t                  state_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [LEN_W-1:0]        cnt_reg;
    logic [DRAIN_W-1:0]      drain_cnt_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [IDX_W-1:0]        index_reg;
    logic                    rd_vld_reg;
    logic [ROWS*DATA_W-1:0]  lane_data_reg;
    logic [ROWS-1:0]         lane_vld_reg;

    // Sequencer: gb_index is registered, so the address for word k is on the bus
    // during the k-th READ cycle and its data returns one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            cnt_reg       <= '0;
            drain_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            index_reg     <= '0;
            rd_vld_reg    <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            rd_vld_reg <= (state_reg == READ);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg  <= len;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (len == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            index_reg <= base;
                        end
                    end
                end
                READ: begin
                    if (cnt_reg == len_reg - 1'b1) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        index_reg <= index_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    logic [DATA_W-1:0] byte_in   [ROWS];
    logic [DATA_W-1:0] skew_data [ROWS];
    logic [ROWS-1:0]   skew_vld;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            // Gate data with rd_vld so idle lanes carry zeros through the skew.
            assign byte_in[gi] = rd_vld_reg ? gb_data[gi*DATA_W +: DATA_W] : '0;

            skew_line #(
                .DEPTH (gi)
            ) u_skew (
                .clk      (clk),
                .rst      (rst),
                .in_data  (byte_in[gi]),
                .in_vld   (rd_vld_reg),
                .out_data (skew_data[gi]),
                .out_vld  (skew_vld[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_data_reg <= '0;
            lane_vld_reg  <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                lane_data_reg[r*DATA_W +: DATA_W] <= skew_vld[r] ? skew_data[r] : '0;
            end
            lane_vld_reg <= skew_vld;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign gb_wr_en  = 1'b0;
    assign gb_index  = index_reg;
    assign lane_data = lane_data_reg;
    assign lane_vld  = lane_vld_reg;

endmodule

// File: tb/tb_gbuff_row_feeder.sv
// Directed plus random commands against a cycle-indexed expectation table built
// from the feeder's timing rules (word k lane r at t+3+k+r, done at t+3+len+ROWS).
module tb_gbuff_row_feeder;
    import gbuff_row_feeder_pkg::*;

    localparam int NCYC = 4096;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [IDX_W-1:0]       base = '0;
    logic [LEN_W-1:0]       len = '0;
    logic                   busy;
    logic                   done;
    logic                   gb_wr_en;
    logic [IDX_W-1:0]       gb_index;
    logic [WORD_SIZE-1:0]   gb_data;
    logic [ROWS*DATA_W-1:0] lane_data;
    logic [ROWS-1:0]        lane_vld;

    gbuff_row_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .gb_wr_en  (gb_wr_en),
        .gb_index  (gb_index),
        .gb_data   (gb_data),
        .lane_data (lane_data),
        .lane_vld  (lane_vld)
    );

    always #5 clk = ~clk;

    // Global buffer with one-cycle registered read.
    logic [WORD_SIZE-1:0] gb_mem [65536];
    always @(posedge clk) gb_data <= gb_mem[gb_index];

    logic [ROWS*DATA_W-1:0] exp_ld   [NCYC];
    logic [ROWS-1:0]        exp_vld  [NCYC];
    logic                   exp_done [NCYC];
    logic                   exp_busy [NCYC];
    logic [IDX_W-1:0]       exp_idx  [NCYC];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int idle_from = 0;
    bit chk_en = 1'b0;

    task automatic check_now();
        checks++;
        assert (lane_data === exp_ld[cyc]) else begin
            errors++;
            $error("FAIL lane_data cyc=%0d got=%h exp=%h", cyc, lane_data, exp_ld[cyc]);
        end
        checks++;
        assert (lane_vld === exp_vld[cyc]) else begin
            errors++;
            $error("FAIL lane_vld cyc=%0d got=%b exp=%b", cyc, lane_vld, exp_vld[cyc]);
        end
        checks++;
        assert (done === exp_done[cyc]) else begin
            errors++;
            $error("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done[cyc]);
        end
        checks++;
        assert (busy === exp_busy[cyc]) else begin
            errors++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy[cyc]);
        end
        checks++;
        assert (gb_index === exp_idx[cyc]) else begin
            errors++;
            $error("FAIL gb_index cyc=%0d got=%h exp=%h", cyc, gb_index, exp_idx[cyc]);
        end
        checks++;
        assert (gb_wr_en === 1'b0) else begin
            errors++;
            $error("FAIL gb_wr_en cyc=%0d got=%b exp=0", cyc, gb_wr_en);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NCYC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
            $fatal(1, "cycle budget exhausted");
        end
        if (chk_en) check_now();
    endtask

    // Record what a start in the current cycle must produce, if the feeder is idle.
    task automatic schedule(input logic [IDX_W-1:0] b, input int n);
        int t;
        int d;
        logic [WORD_SIZE-1:0] w;
        t = cyc;
        if (t < idle_from) return;
        d = (n == 0) ? t + 1 : t + 3 + n + ROWS;
        if (d + 2 >= NCYC) begin
            $display("FAIL schedule_budget end=%0d limit=%0d", d, NCYC);
            $fatal(1, "schedule exceeds table");
        end
        if (n != 0) begin
            for (int k = 0; k < n; k++) begin
                w = gb_mem[16'(b + k)];
                for (int r = 0; r < ROWS; r++) begin
                    exp_ld[t+3+k+r][r*DATA_W +: DATA_W] = w[r*DATA_W +: DATA_W];
                    exp_vld[t+3+k+r][r] = 1'b1;
                end
            end
            for (int c = t + 1; c < NCYC; c++) begin
                exp_idx[c] = 16'(b + ((c - t - 1 < n - 1) ? (c - t - 1) : (n - 1)));
            end
        end
        for (int c = t + 1; c <= d; c++) exp_busy[c] = 1'b1;
        exp_done[d] = 1'b1;
        idle_from = d + 1;
    endtask

    task automatic issue(input logic [IDX_W-1:0] b, input int n);
        start = 1'b1;
        base  = b;
        len   = LEN_W'(n);
        $display("cyc=%0d start base=%h len=%0d accepted=%0d", cyc, b, n, (cyc >= idle_from) ? 1 : 0);
        schedule(b, n);
        step();
        start = 1'b0;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        $display("cyc=%0d reset", cyc);
        for (int c = cyc + 1; c < NCYC; c++) begin
            exp_ld[c]   = '0;
            exp_vld[c]  = '0;
            exp_done[c] = 1'b0;
            exp_busy[c] = 1'b0;
            exp_idx[c]  = '0;
        end
        idle_from = cyc + 1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int t0;
        logic [IDX_W-1:0] b;

        for (int i = 0; i < 65536; i++) gb_mem[i] = $urandom;
        for (int c = 0; c < NCYC; c++) begin
            exp_ld[c]   = '0;
            exp_vld[c]  = '0;
            exp_done[c] = 1'b0;
            exp_busy[c] = 1'b0;
            exp_idx[c]  = '0;
        end

        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        idle_from = cyc;
        step();

        // Basic stream
        gb_mem[10] = 32'h0403_0201;
        gb_mem[11] = 32'h0807_0605;
        gb_mem[12] = 32'h0C0B_0A09;
        issue(16'd10, 3);
        run_until(idle_from + 1);

        // Zero length
        issue(16'h1234, 0);
        run_until(idle_from + 1);

        // Index wrap
        issue(16'hFFFE, 4);
        run_until(idle_from + 1);

        // Start while busy is ignored
        issue(16'd100, 6);
        step();
        step();
        issue(16'd500, 9);
        run_until(idle_from + 1);

        // Reset mid-command, then a clean command
        issue(16'd200, 8);
        t0 = cyc - 1;
        run_until(t0 + 4);
        do_reset();
        step();
        issue(16'd300, 5);
        run_until(idle_from);

        // Back-to-back: start in the cycle after done
        issue(16'd400, 7);
        run_until(idle_from);
        issue(16'd410, 3);
        run_until(idle_from + 1);

        // Random commands with random gaps and occasional starts while busy
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 20);
            b = 16'($urandom);
            run_until(idle_from + $urandom_range(0, 3));
            issue(b, n);
            if ($urandom_range(0, 3) == 0 && n > 1) begin
                step();
                issue(16'($urandom), $urandom_range(0, 20));
            end
        end
        run_until(idle_from + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
